fetch_pc_unit: RTL and testbench

Parametrised fetch-stage program counter for the pipelined MIPS core: holds the current fetch address `pc` and `pc4`, and chooses the next PC from the sequential path, a branch/jump target, an ERET return address or the exception vector. Unlike the single-select PC register it replaces, it never loses a redirect that arrives while fetch is stalled: a one-entry pending buffer holds it until the stall releases. It also flags fetch address errors (AdEL). It sits at the head of IF, driving the instruction memory address and the IF/ID register.

---
 rtl/pc_pkg.sv | 21 ++
 rtl/pc_redirect_buf.sv | 42 ++++
 rtl/fetch_pc_unit.sv | 123 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program counter.
//   rd_cls_e     - 2-bit redirect class; a larger value means higher priority
//   EXC_ADEL     - exception code for a fetch address error
//   DEF_*        - default reset/exception vectors and legal text window
package pc_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_BR   = 2'd1,
        RD_ERET = 2'd2,
        RD_EXC  = 2'd3
    } rd_cls_e;

    localparam logic [4:0]  EXC_ADEL      = 5'd4;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] DEF_TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] DEF_TEXT_HI   = 32'h0000_6FFC;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer holding a redirect (class + target)
// that arrived while fetch was stalled.
//   clk, reset      - clock, synchronous active-high reset
//   i_stall         - fetch stalled; entry is only captured/kept while high
//   i_flush         - exception redirect; discards the entry
//   i_live_cls/tgt  - redirect presented this cycle (never RD_EXC)
//   o_pend_cls/tgt  - buffered entry; RD_NONE means empty
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_flush,
    input  rd_cls_e           i_live_cls,
    input  logic [ADDR_W-1:0] i_live_tgt,
    output rd_cls_e           o_pend_cls,
    output logic [ADDR_W-1:0] o_pend_tgt
);

    rd_cls_e           r_cls;
    logic [ADDR_W-1:0] r_tgt;

    always_ff @(posedge clk) begin
        if (reset || i_flush || !i_stall) begin
            // Once the stall releases the entry has been consumed by the
            // next-PC mux on this same edge.
            r_cls <= RD_NONE;
        end else if (i_live_cls != RD_NONE && i_live_cls >= r_cls) begin
            // Newer request of equal or higher class replaces the entry;
            // lower-class requests are dropped.
            r_cls <= i_live_cls;
            r_tgt <= i_live_tgt;
        end
    end

    assign o_pend_cls = r_cls;
    assign o_pend_tgt = r_tgt;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage program counter with a pending-redirect buffer
// so that redirects arriving during a stall are not lost.
//   clk, reset        - clock, synchronous active-high reset
//   stall             - hold pc/pc4 (hazard unit)
//   br_valid/target   - branch/jump redirect
//   eret_req/epc      - return from exception
//   exc_req           - exception redirect to EXC_VEC; overrides stall
//   pc, pc4           - registered fetch address and fetch address + 4
//   pend_valid        - a redirect is buffered
//   fetch_exc         - current pc is misaligned or outside the text window
//   exc_code          - EXC_ADEL when fetch_exc, else 0
module fetch_pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter logic [ADDR_W-1:0] TEXT_LO   = ADDR_W'(DEF_TEXT_LO),
    parameter logic [ADDR_W-1:0] TEXT_HI   = ADDR_W'(DEF_TEXT_HI)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    input  logic              exc_req,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              pend_valid,
    output logic              fetch_exc,
    output logic [4:0]        exc_code
);

    typedef enum logic [1:0] {RUN, RUN_STALL, PEND} fsm_e;

    fsm_e              r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc4;

    rd_cls_e           w_live_cls;
    logic [ADDR_W-1:0] w_live_tgt;
    rd_cls_e           w_pend_cls;
    logic [ADDR_W-1:0] w_pend_tgt;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_fetch_exc;

    // Live (non-exception) redirect; eret outranks a branch.
    always_comb begin
        w_live_cls = RD_NONE;
        w_live_tgt = br_target;
        if (eret_req) begin
            w_live_cls = RD_ERET;
            w_live_tgt = epc;
        end else if (br_valid) begin
            w_live_cls = RD_BR;
            w_live_tgt = br_target;
        end
    end

    pc_redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .i_stall    (stall),
        .i_flush    (exc_req),
        .i_live_cls (w_live_cls),
        .i_live_tgt (w_live_tgt),
        .o_pend_cls (w_pend_cls),
        .o_pend_tgt (w_pend_tgt)
    );

    // Next-PC mux; on equal class the live request beats the buffered one.
    always_comb begin
        w_next_pc = r_pc;
        if (exc_req) begin
            w_next_pc = EXC_VEC;
        end else if (!stall) begin
            if (w_live_cls != RD_NONE && w_live_cls >= w_pend_cls)
                w_next_pc = w_live_tgt;
            else if (w_pend_cls != RD_NONE)
                w_next_pc = w_pend_tgt;
            else
                w_next_pc = r_pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_VEC;
            r_pc4 <= RESET_VEC + ADDR_W'(4);
        end else begin
            r_pc  <= w_next_pc;
            r_pc4 <= w_next_pc + ADDR_W'(4);
        end
    end

    // Stall/pending tracker; PEND mirrors a non-empty buffer.
    always_ff @(posedge clk) begin
        if (reset || exc_req) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN, RUN_STALL: begin
                    if (!stall)                      r_state <= RUN;
                    else if (w_live_cls != RD_NONE)  r_state <= PEND;
                    else                             r_state <= RUN_STALL;
                end
                PEND:    r_state <= stall ? PEND : RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    assign w_fetch_exc = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);

    assign pc         = r_pc;
    assign pc4        = r_pc4;
    assign pend_valid = (r_state == PEND);
    assign fetch_exc  = w_fetch_exc;
    assign exc_code   = w_fetch_exc ? EXC_ADEL : 5'd0;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, eret_req, exc_req;
    logic [31:0] br_target, epc;
    logic [31:0] pc, pc4;
    logic        pend_valid, fetch_exc;
    logic [4:0]  exc_code;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        pend;
        logic        fexc;
        logic [4:0]  code;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_pc_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_target  (br_target),
        .eret_req   (eret_req),
        .epc        (epc),
        .exc_req    (exc_req),
        .pc         (pc),
        .pc4        (pc4),
        .pend_valid (pend_valid),
        .fetch_exc  (fetch_exc),
        .exc_code   (exc_code)
    );

    // Reference address check against the default text window.
    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
    endfunction

    // Drive one cycle of inputs, queue the expected post-edge state, then
    // sample 1 time unit after the edge and compare.
    task automatic step(input string tag, input logic rst, input logic stl,
                        input logic br, input logic [31:0] btgt,
                        input logic er, input logic [31:0] ep, input logic ex,
                        input logic [31:0] exp_pc, input logic exp_pend);
        exp_t e, got;
        reset = rst; stall = stl; br_valid = br; br_target = btgt;
        eret_req = er; epc = ep; exc_req = ex;
        e.pc   = exp_pc;
        e.pc4  = exp_pc + 32'd4;
        e.pend = exp_pend;
        e.fexc = bad_addr(exp_pc);
        e.code = e.fexc ? 5'd4 : 5'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got = '{pc: pc, pc4: pc4, pend: pend_valid, fexc: fetch_exc, code: exc_code};
        n_vec++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: got pc=%h pc4=%h pend=%b fexc=%b code=%0d, want pc=%h pc4=%h pend=%b fexc=%b code=%0d",
                   tag, got.pc, got.pc4, got.pend, got.fexc, got.code,
                   e.pc, e.pc4, e.pend, e.fexc, e.code);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_valid = 1'b0; eret_req = 1'b0;
        exc_req = 1'b0; br_target = '0; epc = '0;
        #1;
        // args: tag rst stall br btgt eret epc exc | exp_pc exp_pend
        step("reset0",   1, 0, 0, 0,            0, 0,            0, 32'h3000, 0);
        step("reset1",   1, 0, 0, 0,            0, 0,            0, 32'h3000, 0);
        step("seq1",     0, 0, 0, 0,            0, 0,            0, 32'h3004, 0);
        step("seq2",     0, 0, 0, 0,            0, 0,            0, 32'h3008, 0);
        step("seq3",     0, 0, 0, 0,            0, 0,            0, 32'h300C, 0);
        step("seq4",     0, 0, 0, 0,            0, 0,            0, 32'h3010, 0);
        // branch captured during stall
        step("brstl1",   0, 1, 1, 32'h3400,     0, 0,            0, 32'h3010, 1);
        step("brstl2",   0, 1, 0, 0,            0, 0,            0, 32'h3010, 1);
        step("brstl3",   0, 1, 0, 0,            0, 0,            0, 32'h3010, 1);
        step("brrel",    0, 0, 0, 0,            0, 0,            0, 32'h3400, 0);
        // plain stall with no redirect
        step("nostl",    0, 1, 0, 0,            0, 0,            0, 32'h3400, 0);
        step("nostlrel", 0, 0, 0, 0,            0, 0,            0, 32'h3404, 0);
        // br then eret: eret overwrites
        step("ow_br",    0, 1, 1, 32'h3400,     0, 0,            0, 32'h3404, 1);
        step("ow_eret",  0, 1, 0, 0,            1, 32'h3500,     0, 32'h3404, 1);
        step("ow_rel",   0, 0, 0, 0,            0, 0,            0, 32'h3500, 0);
        // eret then br: br dropped
        step("dr_eret",  0, 1, 0, 0,            1, 32'h3600,     0, 32'h3500, 1);
        step("dr_br",    0, 1, 1, 32'h3400,     0, 0,            0, 32'h3500, 1);
        step("dr_rel",   0, 0, 0, 0,            0, 0,            0, 32'h3600, 0);
        // equal class: newer pending replaces older
        step("eq_br1",   0, 1, 1, 32'h3700,     0, 0,            0, 32'h3600, 1);
        step("eq_br2",   0, 1, 1, 32'h3800,     0, 0,            0, 32'h3600, 1);
        step("eq_rel",   0, 0, 0, 0,            0, 0,            0, 32'h3800, 0);
        // pending eret beats live br at release
        step("lv_eret",  0, 1, 0, 0,            1, 32'h3900,     0, 32'h3800, 1);
        step("lv_rel",   0, 0, 1, 32'h3A00,     0, 0,            0, 32'h3900, 0);
        // live br with equal class wins over pending br at release
        step("lq_br",    0, 1, 1, 32'h3B00,     0, 0,            0, 32'h3900, 1);
        step("lq_rel",   0, 0, 1, 32'h3C00,     0, 0,            0, 32'h3C00, 0);
        // exception overrides stall and flushes the pending entry
        step("ex_pend",  0, 1, 1, 32'h3400,     0, 0,            0, 32'h3C00, 1);
        step("ex_hit",   0, 1, 0, 0,            0, 0,            1, 32'h4180, 0);
        step("ex_after", 0, 0, 0, 0,            0, 0,            0, 32'h4184, 0);
        // exception beats simultaneous eret
        step("ex_eret",  0, 0, 0, 0,            1, 32'h3500,     1, 32'h4180, 0);
        // address errors
        step("adr_mis",  0, 0, 1, 32'h3002,     0, 0,            0, 32'h3002, 0);
        step("adr_hi",   0, 0, 1, 32'h7000,     0, 0,            0, 32'h7000, 0);
        step("adr_top",  0, 0, 1, 32'h6FFC,     0, 0,            0, 32'h6FFC, 0);
        step("adr_over", 0, 0, 0, 0,            0, 0,            0, 32'h7000, 0);
        step("adr_lo",   0, 0, 1, 32'h2FFC,     0, 0,            0, 32'h2FFC, 0);
        step("adr_base", 0, 0, 0, 0,            0, 0,            0, 32'h3000, 0);
        // reset while a redirect is pending
        step("rp_pend",  0, 1, 1, 32'h3400,     0, 0,            0, 32'h3000, 1);
        step("rp_rst",   1, 1, 1, 32'h3500,     0, 0,            0, 32'h3000, 0);
        step("rp_after", 0, 0, 0, 0,            0, 0,            0, 32'h3004, 0);
        // wrap at the top of the address space
        step("wrap_br",  0, 0, 1, 32'hFFFF_FFFC, 0, 0,           0, 32'hFFFF_FFFC, 0);
        step("wrap_seq", 0, 0, 0, 0,            0, 0,            0, 32'h0000_0000, 0);

        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
